// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one combinational ALU.
// Each accepted operation goes through three phases: operand capture,
// one evaluation cycle, and a held response. The response is returned
// only to the requester that issued the operation.
//
// Build option: define ALU_ARB_OVERLAP_EN to let a new request be accepted
// in the same cycle as the owner takes its response. This gives a 2-cycle
// issue interval instead of 3. It is undefined by default.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grant is offered to one requester
// EXEC  | ALU evaluating the registered operands; result captured at end
// RESP  | result held for the owning requester until it takes it
module alu_arbiter #(
  parameter int PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_ctrl,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_ctrl,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_out
);

  localparam logic RR_INIT = (PRIO_INIT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        rr_q;
  logic        owner_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [2:0]  op_ctrl_q;
  logic [31:0] result_q;
  logic [1:0]  rsp_valid_q;

  logic        any_valid;
  logic        grant_d;
  logic        owner_rsp_ready;
  logic        accept_win;
  logic        transfer;
  logic [31:0] op_a_d;
  logic [31:0] op_b_d;
  logic [2:0]  op_ctrl_d;

  // Choose the winner. A lone requester always wins. When both request,
  // the round-robin pointer decides.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_d   = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = rr_q;
    end else begin
      grant_d = req1_valid;
    end
  end

  // Decide when a new operation may be accepted. Readies are held low
  // while reset is asserted.
  always_comb begin
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
`ifdef ALU_ARB_OVERLAP_EN
    accept_win = (state_q == IDLE) || ((state_q == RESP) && owner_rsp_ready);
`else
    accept_win = (state_q == IDLE);
`endif
    req0_ready = ~rst & accept_win & any_valid & ~grant_d;
    req1_ready = ~rst & accept_win & any_valid &  grant_d;
    transfer   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // Select the winner's operands for capture.
  always_comb begin
    op_a_d    = grant_d ? req1_a    : req0_a;
    op_b_d    = grant_d ? req1_b    : req0_b;
    op_ctrl_d = grant_d ? req1_ctrl : req0_ctrl;
  end

  // Sequencer. Operands, owner and pointer change only on a transfer. The
  // result register changes only at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= RR_INIT;
      owner_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_ctrl_q   <= '0;
      result_q    <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_ctrl_q <= op_ctrl_d;
            owner_q   <= grant_d;
            rr_q      <= ~grant_d;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_out;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp_valid_q <= 2'b00;
            // A transfer here is only possible when overlap is enabled.
            if (transfer) begin
              op_a_q    <= op_a_d;
              op_b_q    <= op_b_d;
              op_ctrl_q <= op_ctrl_d;
              owner_q   <= grant_d;
              rr_q      <= ~grant_d;
              state_q   <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 2'b00;
        end
      endcase
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_ctrl   = op_ctrl_q;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. A behavioural ALU drives alu_out. A
// cycle-level transaction model predicts the readies and response timing.
// A scoreboard monitor checks every presented response against the
// expected result.
module tb_alu_arbiter;

  localparam int PRIO = 0;
`ifdef ALU_ARB_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctrl;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_INIT(PRIO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_out    (alu_out)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return b[10] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_ctrl);

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  bit          in_flight = 1'b0;
  int          acc_cyc = 0;
  bit          owner_m = 1'b0;
  bit          rr_m = PRIO[0];
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;
  logic [2:0]  cur_c = '0;
  int          cyc = 0;
  bit          acc0_flag, acc1_flag;
  bit          keep0 = 1'b0;
  int          dut_acc0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
  endtask

  // One clock cycle: the inputs are already driven. Predict and check the
  // DUT's readies and response valids, then advance the model.
  task automatic tick();
    bit due, hs, win, any, w;
    #1;
    acc0_flag = 1'b0;
    acc1_flag = 1'b0;
    if (rst) begin
      chk("ready0_in_reset", 32'(req0_ready), 32'd0);
      chk("ready1_in_reset", 32'(req1_ready), 32'd0);
      in_flight = 1'b0;
      rr_m      = PRIO[0];
      owner_m   = 1'b0;
      cur_a = '0; cur_b = '0; cur_c = '0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (req0_valid && req0_ready) dut_acc0++;
      due = in_flight && (cyc >= acc_cyc + 2);
      chk("rsp0_valid", 32'(rsp0_valid), 32'(due && !owner_m));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(due && owner_m));
      chk("alu_a", alu_a, cur_a);
      chk("alu_b", alu_b, cur_b);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(cur_c));
      hs  = due && (owner_m ? rsp1_ready : rsp0_ready);
      win = !in_flight || (OVL && hs);
      any = req0_valid || req1_valid;
      w   = (req0_valid && req1_valid) ? rr_m : req1_valid;
      chk("req0_ready", 32'(req0_ready), 32'(win && any && !w));
      chk("req1_ready", 32'(req1_ready), 32'(win && any && w));
      if (hs) in_flight = 1'b0;
      if (win && any) begin
        if (w) begin
          exp_q1.push_back(alu_ref(req1_a, req1_b, req1_ctrl));
          cur_a = req1_a; cur_b = req1_b; cur_c = req1_ctrl;
          acc1_flag = 1'b1;
        end else begin
          exp_q0.push_back(alu_ref(req0_a, req0_b, req0_ctrl));
          cur_a = req0_a; cur_b = req0_b; cur_c = req0_ctrl;
          acc0_flag = 1'b1;
        end
        in_flight = 1'b1;
        acc_cyc   = cyc;
        owner_m   = w;
        rr_m      = !w;
      end
    end
    @(negedge clk);
    cyc++;
    if (acc0_flag && !keep0) req0_valid = 1'b0;
    if (acc1_flag) req1_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: every presented response must match the oldest
  // expected result for that port. The entry is retired on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (rsp0_valid) begin
          if (exp_q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp0_unexpected: got valid data %h expected no response at t=%0t",
                     rsp0_data, $time);
          end else begin
            chk("rsp0_data", rsp0_data, exp_q0[0]);
            if (rsp0_ready) void'(exp_q0.pop_front());
          end
        end
        if (rsp1_valid) begin
          if (exp_q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp1_unexpected: got valid data %h expected no response at t=%0t",
                     rsp1_data, $time);
          end else begin
            chk("rsp1_data", rsp1_data, exp_q1[0]);
            if (rsp1_ready) void'(exp_q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    ticks(2);
    rst = 1'b0;
    tick();

    // single add
    set0(32'd5, 32'd7, 3'd0);
    ticks(5);

    // contention, repeated twice
    for (int r = 0; r < 2; r++) begin
      set0(32'hF0, 32'h0F, 3'd4);
      set1(32'd1, 32'd2, 3'd3);
      ticks(8);
    end

    // backpressure on requester 1, while requester 0 waits
    rsp1_ready = 1'b0;
    set1(32'hFFFF_FFFF, 32'd1, 3'd2);
    ticks(2);
    set0(32'd3, 32'd4, 3'd0);
    ticks(5);
    rsp1_ready = 1'b1;
    ticks(6);

    // shift passthrough
    set0(32'h8000_0000, 32'h0000_041F, 3'd5);
    ticks(4);
    set0(32'h8000_0000, 32'h0000_001F, 3'd5);
    ticks(4);

    // reset during EXEC, then contention must start from PRIO_INIT
    set0(32'd9, 32'd9, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(4);
    set0(32'd1, 32'd1, 3'd0);
    set1(32'd2, 32'd2, 3'd6);
    ticks(8);

    // sustained issue rate from one requester
    dut_acc0 = 0;
    keep0 = 1'b1;
    set0(32'h1234, 32'h0F0F, 3'd7);
    ticks(12);
    keep0 = 1'b0;
    req0_valid = 1'b0;
    chk("issue_count_12cyc", 32'(dut_acc0), OVL ? 32'd6 : 32'd4);
    ticks(4);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0)
        set0($urandom, $urandom, 3'($urandom_range(0, 7)));
      else if (req0_valid && $urandom_range(0, 9) == 0)
        req0_valid = 1'b0;
      if (!req1_valid && $urandom_range(0, 2) == 0)
        set1($urandom, $urandom, 3'($urandom_range(0, 7)));
      else if (req1_valid && $urandom_range(0, 9) == 0)
        req1_valid = 1'b0;
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    ticks(6);
    chk("scoreboard0_drained", 32'(exp_q0.size()), 32'd0);
    chk("scoreboard1_drained", 32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters, for example the execute stage and an address/branch-compare unit. Each requester has a valid/ready operand port and a valid/ready response port. The block registers operands, sequences one ALU evaluation, and returns the captured result only to the requester that issued it. It sits between the pipeline stages and the `alu` instance, driving the instance's `A`, `B` and `ctrl` inputs and sampling its `out`.

## Interface
- `PRIO_INIT`, default 0: requester favoured by the round-robin pointer after reset (0 or 1).
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req0_a` in 32: requester 0 operand A.
- `req0_b` in 32: requester 0 operand B.
- `req0_ctrl` in 3: requester 0 ALU op (0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 sr, 6 or, 7 and).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_ctrl`: same as requester 0, for requester 1.
- `rsp0_valid` out 1: result available for requester 0.
- `rsp0_ready` in 1: requester 0 takes the result.
- `rsp0_data` out 32: result for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_data`: same as requester 0, for requester 1.
- `alu_a` out 32: drives `alu.A`.
- `alu_b` out 32: drives `alu.B`.
- `alu_ctrl` out 3: drives `alu.ctrl`.
- `alu_out` in 32: from `alu.out`.

## Operation
- FSM states:
  - IDLE: accepts new requests.
  - EXEC: the ALU is evaluating the registered operands.
  - RESP: the result is held for the owning requester.
- Grant, computed combinationally in IDLE:
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester named by pointer `rr` is granted.
- `reqN_ready` = (state==IDLE) & granted==N. A transfer occurs when `reqN_valid & reqN_ready`.
- On a transfer:
  - `a`, `b`, `ctrl` of the winner are latched into the operand register.
  - The winner index is latched into `owner`.
  - `rr` is set to the loser's index (1-owner).
  - Next state is EXEC.
- The operand register drives `alu_a`/`alu_b`/`alu_ctrl` at all times and changes only on a transfer.
- EXEC: `alu_out` is captured into `result` at the end of the cycle; next state is RESP.
- RESP:
  - `rsp<owner>_valid`=1 and `rsp<owner>_data`=`result`; the other requester's valid is 0.
  - On `rsp<owner>_ready`, next state is IDLE. Otherwise the state and `result` hold unchanged.
  - The non-owner's `rspN_ready` is ignored.
- `rspN_data` drives `result` regardless of `rspN_valid`. It is qualified only by valid.
- No arithmetic is done in this block. Results are exactly the `alu` outputs; shift amount is `B[4:0]`.
- A request dropped before its ready is not required to stay valid. The block does not remember unaccepted requests.
- Reset values:
  - State = IDLE, `rr` = `PRIO_INIT`, `owner` = 0.
  - Operand register = 0, so `alu_a`/`alu_b`/`alu_ctrl` = 0.
  - `result` = 0.
  - All `reqN_ready` = 0 while `rst`=1.
  - All `rspN_valid` = 0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is ever produced, and the pointer returns to `PRIO_INIT`.

## Timing
- Accept in cycle N, EXEC in N+1, `rspN_valid` high from N+2.
- Minimum latency from accept to response is 2 cycles.
- Minimum issue interval is 3 cycles per op (accept, EXEC, RESP handshake), with the default build.
- `reqN_ready` combinationally depends on both `reqN_valid` inputs and on state. There is no path from any `reqN_*` input to any `rspN_*` output.
- The `alu` path is combinational from registered operands to `result`. Register-to-register: one full cycle.

## Configuration
- Macro `ALU_ARB_OVERLAP_EN`.
- Undefined: behaviour exactly as described above. New requests are accepted in IDLE only.
- Defined, in RESP, if `rsp<owner>_ready`=1:
  - Grant is computed as in IDLE, and `reqN_ready` may assert in the same cycle.
  - On a transfer, next state is EXEC instead of IDLE, and the operand register, `owner` and `rr` update as normal.
  - Sustained issue interval is 2 cycles.
  - `reqN_ready` then also depends combinationally on `rsp<owner>_ready`.
- Reset behaviour is unchanged by the macro.

## Test plan
- **Single add:** reset, then req0 a=5, b=7, ctrl=0 → `req0_ready`=1 the same cycle; `rsp0_valid`=1, `rsp0_data`=12 two cycles later; `rsp1_valid` stays 0.
- **Contention:** `PRIO_INIT`=0, both valid (req0 xor 0xF0^0x0F, req1 sltu 1<2) → req0 granted first with result 0xFF, then req1 with result 1. Repeat → grant order alternates.
- **Backpressure:** req1 slt a=0xFFFFFFFF, b=1 with `rsp1_ready`=0 for 5 cycles → `rsp1_valid`=1, `rsp1_data`=1 stable; no `reqN_ready` during those cycles; IDLE one cycle after ready.
- **Shift passthrough:** req0 sr a=0x80000000, b=0x41F → `rsp0_data`=0xFFFFFFFF. The same with b=0x01F → 0x00000001.
- **Reset mid-op:** assert `rst` during EXEC → no `rspN_valid` ever; `alu_a`/`alu_b`/`alu_ctrl`=0; pointer = `PRIO_INIT`.
- **Overlap (`ALU_ARB_OVERLAP_EN` defined):** req0 held valid with `rsp0_ready`=1 → a new accept every 2 cycles, coincident with each response handshake.
